ppu_vram_seq: RTL and testbench
===============================

# ppu_vram_seq

Single-clock VRAM access sequencer for the PPU. It replaces the direct dual-port configuration path with NES-accurate $2006/$2007 semantics: a two-write address latch, auto-increment, a delayed read buffer, and an in-block palette register file. Queued CPU accesses are arbitrated against render fetches onto one shared single-port memory (pattern SRAM plus banked nametable RAM), with mirroring generalised over a parametrised bank count. It sits between the CPU register decoder (already synchronised to the PPU clock) and the PPU fetch pipeline.

## Interface
- NT_BANKS, 4, number of physical 1 KB nametable banks, 2 or 4
- CPU_Q_DEPTH, 4, CPU access queue depth, power of two, ≥2
- i_ppu_clk  in  1  clock
- i_ppu_rstn  in  1  reset; asynchronous, active-low
- i_2006_wr / i_2007_wr / i_2007_rd  in  1  one-cycle register access strobes, mutually exclusive
- i_wdata  in  8  CPU write data
- i_inc32  in  1  increment select ($2000 bit 2): 0 → +1, 1 → +32
- i_latch_clr  in  1  clears the $2006 write toggle ($2002 read)
- i_mirror_mode  in  3  0 horizontal, 1 vertical, 2 single-A, 3 single-B, 4 four-screen, others → single-A
- i_gray  in  1  gray mask request
- o_2007_rdata  out  8  CPU read data, valid in the cycle of i_2007_rd
- o_vaddr  out  14  current VRAM address
- o_busy  out  1  CPU queue non-empty
- o_ovf  out  1  sticky: a CPU access was dropped because the queue was full
- i_rend_req  in  1  render fetch request
- i_rend_addr  in  14  render fetch address, < 0x3F00
- o_rend_vld  out  1  render read data valid
- o_rend_rdata  out  8  render read data
- i_plt_addr  in  5  render palette index
- o_plt_rdata  out  8  render palette colour
- o_mem_pt  out  1  1 = pattern SRAM, 0 = nametable RAM
- o_mem_addr  out  13  mapped memory address
- o_mem_we  out  1  memory write enable
- o_mem_wdata  out  8  memory write data
- i_mem_rdata  in  8  memory read data; one-cycle synchronous latency

## Operation
- **$2006 writes.**
  - When toggle = 0: t_hi ← wdata[5:0], toggle ← 1.
  - When toggle = 1: vaddr ← {t_hi, wdata}, toggle ← 0.
  - If i_latch_clr coincides with a write, the write uses the pre-clear toggle value and toggle ends at 0.
- **$2007 access.** Each access increments vaddr by 1 or 32, modulo 2^14, in the strobe cycle.
- **Non-palette access (vaddr < 0x3F00).**
  - A write enqueues {wr, vaddr, wdata}.
  - A read returns the read buffer on o_2007_rdata and enqueues {rd, vaddr}.
  - When a queued read completes, the buffer is loaded with its data.
- **Palette access (vaddr ≥ 0x3F00).**
  - Palette RAM is 32×6 internal registers. Index = vaddr[4:0]. Indices 0x10/0x14/0x18/0x1C alias to 0x00/0x04/0x08/0x0C.
  - A write updates the register immediately and is not queued.
  - A read returns {2'b00, plt[idx]} immediately and enqueues a buffer-fill read of vaddr − 0x1000.
- **Queue overflow.** A queued access arriving when the queue is full is dropped and o_ovf is set. It clears only on reset.
- **Arbitration (per cycle).** i_rend_req has absolute priority. Otherwise the queue head issues and is popped.
- **Address mapping.**
  - addr < 0x2000: o_mem_pt = 1, o_mem_addr = addr[12:0].
  - Otherwise: o_mem_pt = 0, o_mem_addr = {bank, addr[9:0]} zero-extended.
- **Bank selection by mirror mode.**
  - Horizontal: addr[11].
  - Vertical: addr[10].
  - Single-A: 0. Single-B: 1.
  - Four-screen: addr[11:10].
  - With NT_BANKS = 2, four-screen behaves as vertical.
- **Render palette port.** o_plt_rdata ← {2'b00, plt[alias(i_plt_addr)]}; index with [1:0] = 0 reads entry 0x00.

## Timing
- **Reset.**
  - Internal state resets to: vaddr, t_hi, toggle, buffer, palette registers and queue all 0/empty.
  - All outputs reset to 0.
- **Memory issue.**
  - Address/we/wdata are combinational from the granted source in the issue cycle.
  - Read data is captured one cycle later.
- **Render port.** o_rend_vld / o_rend_rdata are asserted in cycle N+1 for a request issued in cycle N.
- **CPU queue.**
  - An access enqueued in cycle N may issue at the earliest in N+1.
  - A queued read updates the buffer at the end of issue cycle + 1.
  - Queued writes and reads retire in order.
- **Palette path.**
  - o_plt_rdata is registered, with one-cycle latency.
  - A palette write in cycle N is visible on o_plt_rdata from N+2.
- **Simultaneous events.**
  - An enqueue and a pop in the same cycle with the queue full is not an overflow.
  - A $2006 write does not alter already-queued addresses.

## Configuration
- `PPU_VRAM_GRAY_EN` defined: o_plt_rdata is masked with 0x30 when i_gray = 1.
- Undefined: i_gray is ignored and o_plt_rdata is unmasked.

## Test plan
- **Address latch and write.** $2006 ← 0x21, $2006 ← 0x08, $2007 ← 0x5A with i_inc32 = 0 → memory write at NT addr 0x108, o_vaddr = 0x2109.
- **Delayed read buffer.** Preload NT 0x2000 = 0x11 and 0x2001 = 0x22; set vaddr = 0x2000, then do three reads → 0x00 (reset buffer), 0x11, 0x22.
- **Palette aliasing and gray mask.** Write 0x3F10 ← 0x2C, then read vaddr 0x3F00 → 0x2C immediately. With `PPU_VRAM_GRAY_EN` and i_gray = 1, i_plt_addr = 0 → o_plt_rdata = 0x20.
- **Mirroring.**
  - Vertical: writing 0x2400 ← 0x77 then reading 0x2C00 → 0x77.
  - Four-screen with NT_BANKS = 4: 0x2C00 reads bank 3, distinct from 0x2400.
- **Arbitration and overflow.**
  - Hold i_rend_req high while issuing 5 $2007 writes (depth 4) → o_busy = 1, o_ovf = 1, and only the first 4 retire after i_rend_req drops.
- **Reset mid-operation.** Assert i_ppu_rstn low with the queue non-empty → queue empty, o_busy = 0, o_vaddr = 0, and no memory write after reset release.

Source files
------------

// File: rtl/ppu_vram_seq.sv
//------------------------------------------------------------------------------
// ppu_vram_seq
// VRAM access sequencer for the PPU. It provides $2006/$2007 semantics: a
// two-write address latch, auto-increment, a delayed read buffer and an
// in-block palette register file. Queued CPU accesses share a single-port
// memory with render fetches. Render fetches always win the memory.
//
// Parameters : NT_BANKS (2 or 4 physical 1 KB nametable banks),
//              CPU_Q_DEPTH (CPU access queue depth, power of two, >= 2)
// Macro      : PPU_VRAM_GRAY_EN - when defined, i_gray masks the render
//              palette colour with 0x30; otherwise i_gray is ignored.
// Ports      : i_ppu_clk / i_ppu_rstn (async, active-low)
//              CPU side  : i_2006_wr, i_2007_wr, i_2007_rd, i_wdata, i_inc32,
//                          i_latch_clr, o_2007_rdata, o_vaddr, o_busy, o_ovf
//              Config    : i_mirror_mode, i_gray
//              Render    : i_rend_req, i_rend_addr, o_rend_vld, o_rend_rdata,
//                          i_plt_addr, o_plt_rdata
//              Memory    : o_mem_pt, o_mem_addr, o_mem_we, o_mem_wdata,
//                          i_mem_rdata (one-cycle synchronous read latency)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module ppu_vram_seq #(
  parameter int NT_BANKS    = 4,
  parameter int CPU_Q_DEPTH = 4
) (
  input  logic        i_ppu_clk,
  input  logic        i_ppu_rstn,
  input  logic        i_2006_wr,
  input  logic        i_2007_wr,
  input  logic        i_2007_rd,
  input  logic [7:0]  i_wdata,
  input  logic        i_inc32,
  input  logic        i_latch_clr,
  input  logic [2:0]  i_mirror_mode,
  input  logic        i_gray,
  output logic [7:0]  o_2007_rdata,
  output logic [13:0] o_vaddr,
  output logic        o_busy,
  output logic        o_ovf,
  input  logic        i_rend_req,
  input  logic [13:0] i_rend_addr,
  output logic        o_rend_vld,
  output logic [7:0]  o_rend_rdata,
  input  logic [4:0]  i_plt_addr,
  output logic [7:0]  o_plt_rdata,
  output logic        o_mem_pt,
  output logic [12:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata
);

  localparam int          QW     = $clog2(CPU_Q_DEPTH);
  localparam logic [QW:0] Q_FULL = (QW+1)'(CPU_Q_DEPTH);

  // CPU palette aliasing: backdrop mirrors 0x10/0x14/0x18/0x1C fold onto 0x0x.
  function automatic logic [4:0] plt_alias(input logic [4:0] idx);
    plt_alias = (idx[1:0] == 2'b00) ? {1'b0, idx[3:0]} : idx;
  endfunction

  // Returns {pt, addr[12:0]} for a 14-bit PPU address under a mirror mode.
  function automatic logic [13:0] map_addr(input logic [13:0] a, input logic [2:0] mode);
    logic [1:0] bank;
    case (mode)
      3'd0:    bank = {1'b0, a[11]};
      3'd1:    bank = {1'b0, a[10]};
      3'd3:    bank = 2'b01;
      3'd4:    bank = (NT_BANKS == 4) ? a[11:10] : {1'b0, a[10]};
      default: bank = 2'b00;
    endcase
    if (a < 14'h2000) map_addr = {1'b1, a[12:0]};
    else              map_addr = {2'b00, bank, a[9:0]};
  endfunction

  logic [13:0] vaddr_q, vaddr_d;
  logic [5:0]  thi_q, thi_d;
  logic        toggle_q, toggle_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        rd_pend_q, rd_pend_d;
  logic        ovf_q, ovf_d;
  logic        rend_vld_q, rend_vld_d;
  logic [7:0]  plt_rdata_q, plt_rdata_d;
  logic [5:0]  plt_q [32];
  logic [5:0]  plt_d [32];
  logic        q_wr_q   [CPU_Q_DEPTH];
  logic        q_wr_d   [CPU_Q_DEPTH];
  logic [13:0] q_addr_q [CPU_Q_DEPTH];
  logic [13:0] q_addr_d [CPU_Q_DEPTH];
  logic [7:0]  q_data_q [CPU_Q_DEPTH];
  logic [7:0]  q_data_d [CPU_Q_DEPTH];
  logic [QW-1:0] head_q, head_d, tail_q, tail_d;
  logic [QW:0]   cnt_q, cnt_d;

  logic        enq, enq_wr, enq_ok, pop, is_plt;
  logic [13:0] enq_addr, step, mem_map;
  logic        mem_we;
  logic [7:0]  mem_wdata, cpu_rdata;
  logic [4:0]  rend_idx;

  always_comb begin
    vaddr_d   = vaddr_q;
    thi_d     = thi_q;
    toggle_d  = toggle_q;
    rbuf_d    = rbuf_q;
    ovf_d     = ovf_q;
    rd_pend_d = 1'b0;
    plt_d     = plt_q;
    q_wr_d    = q_wr_q;
    q_addr_d  = q_addr_q;
    q_data_d  = q_data_q;
    head_d    = head_q;
    tail_d    = tail_q;
    cnt_d     = cnt_q;
    enq       = 1'b0;
    enq_wr    = 1'b0;
    enq_ok    = 1'b0;
    enq_addr  = vaddr_q;
    cpu_rdata = 8'h00;
    mem_map   = 14'h0000;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    is_plt    = (vaddr_q[13:8] == 6'h3F);
    step      = i_inc32 ? 14'd32 : 14'd1;

    // $2006 uses the toggle value from before any coincident clear.
    if (i_2006_wr) begin
      if (!toggle_q) begin
        thi_d    = i_wdata[5:0];
        toggle_d = 1'b1;
      end else begin
        vaddr_d  = {thi_q, i_wdata};
        toggle_d = 1'b0;
      end
    end
    if (i_latch_clr) toggle_d = 1'b0;

    if (i_2007_wr || i_2007_rd) begin
      vaddr_d = vaddr_q + step;
      if (is_plt) begin
        if (i_2007_wr) begin
          plt_d[plt_alias(vaddr_q[4:0])] = i_wdata[5:0];
        end else begin
          // Palette reads answer at once but still refill the buffer from
          // the nametable underneath.
          cpu_rdata = {2'b00, plt_q[plt_alias(vaddr_q[4:0])]};
          enq       = 1'b1;
          enq_addr  = vaddr_q - 14'h1000;
        end
      end else begin
        enq    = 1'b1;
        enq_wr = i_2007_wr;
        if (i_2007_rd) cpu_rdata = rbuf_q;
      end
    end

    // Render fetches own the memory whenever they ask for it.
    pop = !i_rend_req && (cnt_q != '0);
    if (i_rend_req) begin
      mem_map = map_addr(i_rend_addr, i_mirror_mode);
    end else if (pop) begin
      mem_map   = map_addr(q_addr_q[head_q], i_mirror_mode);
      mem_we    = q_wr_q[head_q];
      mem_wdata = q_data_q[head_q];
      rd_pend_d = !q_wr_q[head_q];
      head_d    = head_q + QW'(1);
    end

    if (rd_pend_q) rbuf_d = i_mem_rdata;

    // A pop frees the head slot in the same cycle, so full+pop still accepts.
    if (enq) begin
      if ((cnt_q != Q_FULL) || pop) begin
        enq_ok           = 1'b1;
        q_wr_d[tail_q]   = enq_wr;
        q_addr_d[tail_q] = enq_addr;
        q_data_d[tail_q] = i_wdata;
        tail_d           = tail_q + QW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    case ({enq_ok, pop})
      2'b10:   cnt_d = cnt_q + (QW+1)'(1);
      2'b01:   cnt_d = cnt_q - (QW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    rend_vld_d  = i_rend_req;
    // Render side: every [1:0] == 0 index shows the universal backdrop.
    rend_idx    = (i_plt_addr[1:0] == 2'b00) ? 5'd0 : i_plt_addr;
    plt_rdata_d = {2'b00, plt_q[rend_idx]};
`ifdef PPU_VRAM_GRAY_EN
    if (i_gray) plt_rdata_d = plt_rdata_d & 8'h30;
`endif
  end

`ifndef PPU_VRAM_GRAY_EN
  logic unused_gray;
  assign unused_gray = i_gray;
`endif

  always_ff @(posedge i_ppu_clk or negedge i_ppu_rstn) begin
    if (!i_ppu_rstn) begin
      vaddr_q     <= '0;
      thi_q       <= '0;
      toggle_q    <= 1'b0;
      rbuf_q      <= '0;
      rd_pend_q   <= 1'b0;
      ovf_q       <= 1'b0;
      rend_vld_q  <= 1'b0;
      plt_rdata_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < 32; i++) plt_q[i] <= '0;
      for (int i = 0; i < CPU_Q_DEPTH; i++) begin
        q_wr_q[i]   <= 1'b0;
        q_addr_q[i] <= '0;
        q_data_q[i] <= '0;
      end
    end else begin
      vaddr_q     <= vaddr_d;
      thi_q       <= thi_d;
      toggle_q    <= toggle_d;
      rbuf_q      <= rbuf_d;
      rd_pend_q   <= rd_pend_d;
      ovf_q       <= ovf_d;
      rend_vld_q  <= rend_vld_d;
      plt_rdata_q <= plt_rdata_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      plt_q       <= plt_d;
      q_wr_q      <= q_wr_d;
      q_addr_q    <= q_addr_d;
      q_data_q    <= q_data_d;
    end
  end

  assign o_2007_rdata = cpu_rdata;
  assign o_vaddr      = vaddr_q;
  assign o_busy       = (cnt_q != '0);
  assign o_ovf        = ovf_q;
  assign o_rend_vld   = rend_vld_q;
  assign o_rend_rdata = rend_vld_q ? i_mem_rdata : 8'h00;
  assign o_plt_rdata  = plt_rdata_q;
  assign o_mem_pt     = mem_map[13];
  assign o_mem_addr   = mem_map[12:0];
  assign o_mem_we     = mem_we;
  assign o_mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_ppu_vram_seq.sv
`timescale 1ns/1ps
module tb_ppu_vram_seq;

  localparam int NT_BANKS    = 4;
  localparam int CPU_Q_DEPTH = 4;

  logic        clk, rst_n;
  logic        i_2006_wr, i_2007_wr, i_2007_rd, i_inc32, i_latch_clr, i_gray;
  logic [7:0]  i_wdata;
  logic [2:0]  mirror_mode;
  logic [7:0]  o_2007_rdata;
  logic [13:0] o_vaddr;
  logic        o_busy, o_ovf;
  logic        i_rend_req;
  logic [13:0] i_rend_addr;
  logic        o_rend_vld;
  logic [7:0]  o_rend_rdata;
  logic [4:0]  i_plt_addr;
  logic [7:0]  o_plt_rdata;
  logic        o_mem_pt, o_mem_we;
  logic [12:0] o_mem_addr;
  logic [7:0]  o_mem_wdata, mem_rdata;

  ppu_vram_seq #(.NT_BANKS(NT_BANKS), .CPU_Q_DEPTH(CPU_Q_DEPTH)) dut (
    .i_ppu_clk(clk), .i_ppu_rstn(rst_n),
    .i_2006_wr(i_2006_wr), .i_2007_wr(i_2007_wr), .i_2007_rd(i_2007_rd),
    .i_wdata(i_wdata), .i_inc32(i_inc32), .i_latch_clr(i_latch_clr),
    .i_mirror_mode(mirror_mode), .i_gray(i_gray),
    .o_2007_rdata(o_2007_rdata), .o_vaddr(o_vaddr), .o_busy(o_busy), .o_ovf(o_ovf),
    .i_rend_req(i_rend_req), .i_rend_addr(i_rend_addr),
    .o_rend_vld(o_rend_vld), .o_rend_rdata(o_rend_rdata),
    .i_plt_addr(i_plt_addr), .o_plt_rdata(o_plt_rdata),
    .o_mem_pt(o_mem_pt), .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical memory attached to the DUT: index {pt, addr13}.
  logic [7:0] sram [0:16383];
  always @(posedge clk) begin
    if (o_mem_we) sram[{o_mem_pt, o_mem_addr}] <= o_mem_wdata;
    mem_rdata <= sram[{o_mem_pt, o_mem_addr}];
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state.
  int         m_vaddr, m_thi;
  bit         m_toggle;
  logic [7:0] m_buf;
  logic [5:0] m_plt [32];
  logic [7:0] mem_model [0:16383];

  logic [7:0]  exp_rd[$];
  logic [21:0] exp_wr[$];
  logic [7:0]  exp_rend[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT output with no expected entry", name);
  endtask

  // Physical location of a PPU address, from the mirroring rules.
  function automatic int phys(input int a);
    int quad, bank;
    if (a < 'h2000) return 8192 + a;
    quad = (a / 1024) % 4;
    case (mirror_mode)
      3'd0:    bank = quad / 2;
      3'd1:    bank = quad % 2;
      3'd3:    bank = 1;
      3'd4:    bank = (NT_BANKS == 4) ? quad : quad % 2;
      default: bank = 0;
    endcase
    return bank * 1024 + a % 1024;
  endfunction

  function automatic int pal_idx(input int a);
    int i;
    i = a % 32;
    if (i >= 16 && i % 4 == 0) i = i - 16;
    return i;
  endfunction

  function automatic int rend_pal(input int a);
    int i;
    i = a % 32;
    if (i % 4 == 0) i = 0;
    return i;
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i_2007_rd) begin
        if (exp_rd.size() == 0) fail_evt("cpu_rdata");
        else check("cpu_rdata", 32'(o_2007_rdata), 32'(exp_rd.pop_front()));
      end
      if (o_mem_we) begin
        if (exp_wr.size() == 0) fail_evt("mem_wr");
        else check("mem_wr", 32'({o_mem_pt, o_mem_addr, o_mem_wdata}), 32'(exp_wr.pop_front()));
      end
      if (o_rend_vld) begin
        if (exp_rend.size() == 0) fail_evt("rend_rdata");
        else check("rend_rdata", 32'(o_rend_rdata), 32'(exp_rend.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w6, input logic w7, input logic r7, input logic clr,
                       input logic [7:0] d, input logic inc);
    i_2006_wr = w6; i_2007_wr = w7; i_2007_rd = r7; i_latch_clr = clr;
    i_wdata = d; i_inc32 = inc;
    tick();
    i_2006_wr = 1'b0; i_2007_wr = 1'b0; i_2007_rd = 1'b0; i_latch_clr = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (o_busy && n < 40) begin
      tick();
      n++;
    end
    check("drain_busy", 32'(o_busy), 32'(0));
    tick();
    check("vaddr", 32'(o_vaddr), 32'(m_vaddr));
  endtask

  task automatic model_wr(input logic [7:0] d, input logic inc, input bit drop);
    int a;
    a = m_vaddr;
    if (a >= 'h3F00) m_plt[pal_idx(a)] = d[5:0];
    else if (!drop) begin
      exp_wr.push_back({14'(phys(a)), d});
      mem_model[phys(a)] = d;
    end
    m_vaddr = (a + (inc ? 32 : 1)) % 16384;
  endtask

  task automatic cpu_2006(input logic [7:0] d, input logic clr);
    if (!m_toggle) begin
      m_thi = int'(d[5:0]);
      m_toggle = 1'b1;
    end else begin
      m_vaddr = m_thi * 256 + int'(d);
      m_toggle = 1'b0;
    end
    if (clr) m_toggle = 1'b0;
    drive(1'b1, 1'b0, 1'b0, clr, d, 1'b0);
    wait_drain();
  endtask

  task automatic cpu_clr();
    m_toggle = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    wait_drain();
  endtask

  task automatic cpu_wr(input logic [7:0] d, input logic inc);
    model_wr(d, inc, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, d, inc);
    wait_drain();
  endtask

  task automatic cpu_rd(input logic inc);
    int a;
    a = m_vaddr;
    if (a >= 'h3F00) begin
      exp_rd.push_back({2'b00, m_plt[pal_idx(a)]});
      m_buf = mem_model[phys(a - 'h1000)];
    end else begin
      exp_rd.push_back(m_buf);
      m_buf = mem_model[phys(a)];
    end
    m_vaddr = (a + (inc ? 32 : 1)) % 16384;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, inc);
    wait_drain();
  endtask

  task automatic rend_rd(input int a);
    exp_rend.push_back(mem_model[phys(a)]);
    i_rend_req = 1'b1;
    i_rend_addr = 14'(a);
    tick();
    i_rend_req = 1'b0;
  endtask

  task automatic plt_chk(input logic [4:0] idx, input logic g);
    logic [7:0] e;
    i_plt_addr = idx;
    i_gray = g;
    tick();
    e = {2'b00, m_plt[rend_pal(int'(idx))]};
`ifdef PPU_VRAM_GRAY_EN
    if (g) e = e & 8'h30;
`endif
    check("plt_port", 32'(o_plt_rdata), 32'(e));
  endtask

  task automatic model_reset();
    m_vaddr = 0; m_thi = 0; m_toggle = 1'b0; m_buf = 8'h00;
    for (int i = 0; i < 32; i++) m_plt[i] = 6'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_2006_wr = 0; i_2007_wr = 0; i_2007_rd = 0; i_latch_clr = 0; i_inc32 = 0;
    i_wdata = 0; i_gray = 0; mirror_mode = 0; i_rend_req = 0; i_rend_addr = 0;
    i_plt_addr = 0; mem_rdata = 0;
    for (int i = 0; i < 16384; i++) begin
      sram[i] = 8'h00;
      mem_model[i] = 8'h00;
    end
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vaddr", 32'(o_vaddr), 32'(0));
    check("rst_busy", 32'(o_busy), 32'(0));
    check("rst_ovf", 32'(o_ovf), 32'(0));
    check("rst_rend_vld", 32'(o_rend_vld), 32'(0));
    check("rst_mem_we", 32'(o_mem_we), 32'(0));
    check("rst_plt", 32'(o_plt_rdata), 32'(0));
    check("rst_rdata", 32'(o_2007_rdata), 32'(0));
    rst_n = 1'b1;
    tick();

    // Address latch and write.
    cpu_2006(8'h21, 1'b0);
    cpu_2006(8'h08, 1'b0);
    cpu_wr(8'h5A, 1'b0);
    check("latch_vaddr", 32'(o_vaddr), 32'h2109);

    // Delayed read buffer.
    cpu_2006(8'h20, 1'b0); cpu_2006(8'h00, 1'b0);
    cpu_wr(8'h11, 1'b0);
    cpu_wr(8'h22, 1'b0);
    cpu_2006(8'h20, 1'b0); cpu_2006(8'h00, 1'b0);
    cpu_rd(1'b0); cpu_rd(1'b0); cpu_rd(1'b0);

    // Palette aliasing and gray mask.
    cpu_2006(8'h3F, 1'b0); cpu_2006(8'h10, 1'b0);
    cpu_wr(8'h2C, 1'b0);
    cpu_2006(8'h3F, 1'b0); cpu_2006(8'h00, 1'b0);
    cpu_rd(1'b0);
    plt_chk(5'd0, 1'b1);
    plt_chk(5'd0, 1'b0);

    // Mirroring.
    mirror_mode = 3'd1;
    cpu_2006(8'h24, 1'b0); cpu_2006(8'h00, 1'b0);
    cpu_wr(8'h77, 1'b0);
    cpu_2006(8'h2C, 1'b0); cpu_2006(8'h00, 1'b0);
    cpu_rd(1'b0); cpu_rd(1'b0);
    mirror_mode = 3'd4;
    cpu_2006(8'h2C, 1'b0); cpu_2006(8'h00, 1'b0);
    cpu_wr(8'h99, 1'b1);
    cpu_2006(8'h24, 1'b0); cpu_2006(8'h00, 1'b0);
    cpu_rd(1'b0); cpu_rd(1'b0);
    rend_rd('h2C00);
    rend_rd('h2400);

    // Arbitration and overflow: render holds the memory while 5 writes arrive.
    cpu_2006(8'h20, 1'b0); cpu_2006(8'h80, 1'b0);
    check("ovf_before", 32'(o_ovf), 32'(0));
    for (int i = 0; i < 7; i++) begin
      i_rend_req = 1'b1;
      i_rend_addr = 14'h0040;
      exp_rend.push_back(mem_model[phys('h0040)]);
      if (i < 5) begin
        model_wr(8'hA0 + 8'(i), 1'b0, i == 4);
        i_2007_wr = 1'b1;
        i_wdata = 8'hA0 + 8'(i);
        i_inc32 = 1'b0;
      end else begin
        i_2007_wr = 1'b0;
      end
      tick();
    end
    i_2007_wr = 1'b0;
    check("ovf_busy", 32'(o_busy), 32'(1));
    check("ovf_flag", 32'(o_ovf), 32'(1));
    i_rend_req = 1'b0;
    wait_drain();
    check("ovf_sticky", 32'(o_ovf), 32'(1));
    check("ovf_retired", 32'(exp_wr.size()), 32'(0));

    // Randomised traffic.
    for (int it = 0; it < 200; it++) begin
      int r;
      logic inc;
      r = int'($urandom_range(0, 9));
      inc = 1'($urandom);
      if (r < 3) begin
        cpu_2006(($urandom_range(0, 2) == 0) ? 8'h3F : 8'($urandom), $urandom_range(0, 5) == 0);
      end else if (r < 6) begin
        cpu_wr(8'($urandom), inc);
      end else if (r < 9) begin
        cpu_rd(inc);
      end else begin
        mirror_mode = 3'($urandom);
        cpu_clr();
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) rend_rd(int'($urandom_range(0, 'h3EFF)));
      plt_chk(5'($urandom), 1'($urandom));
    end

    // Reset while the queue holds writes that render is blocking.
    cpu_clr();
    cpu_2006(8'h21, 1'b0); cpu_2006(8'h00, 1'b0);
    i_rend_req = 1'b1;
    i_rend_addr = 14'h0000;
    for (int i = 0; i < 3; i++) begin
      exp_rend.push_back(mem_model[phys(0)]);
      i_2007_wr = (i < 2);
      i_wdata = 8'hEE;
      i_inc32 = 1'b0;
      tick();
    end
    i_2007_wr = 1'b0;
    check("prerst_busy", 32'(o_busy), 32'(1));
    #2;
    rst_n = 1'b0;
    i_rend_req = 1'b0;
    #1;
    exp_rend.delete();
    model_reset();
    check("midrst_busy", 32'(o_busy), 32'(0));
    check("midrst_vaddr", 32'(o_vaddr), 32'(0));
    check("midrst_ovf", 32'(o_ovf), 32'(0));
    check("midrst_rend_vld", 32'(o_rend_vld), 32'(0));
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("postrst_busy", 32'(o_busy), 32'(0));

    check("left_rd", 32'(exp_rd.size()), 32'(0));
    check("left_wr", 32'(exp_wr.size()), 32'(0));
    check("left_rend", 32'(exp_rend.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
